seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment driver that generalises the fixed 8-digit display block. It scans NUM_DIGITS hex digits at a programmable refresh rate and inserts anti-ghosting dead time between digits. Loads are double-buffered, so the display only updates at frame boundaries and never tears. It sits between the datapath's result registers and the board's segment and anode pins.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_seg_scanner.sv | 152 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment encoding is {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry i holds the active-low pattern for hex digit i (MSB entry is F).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed, double-buffered seven-segment scanner with inter-digit dead time.
// Define LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  output logic [6:0]              out7,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    FrameTick
);

  localparam int unsigned CntMax = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] ShowLast = CW'(REFRESH_DIV - 1);
  // With no dead time the reset-state DEAD still lasts one cycle before the first SHOW.
  localparam logic [CW-1:0] DeadLast = (DEAD_CYCLES > 1) ? CW'(DEAD_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IdxLast  = IW'(NUM_DIGITS - 1);

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                presc_q, presc_d;
  logic [NUM_DIGITS-1:0][3:0]   display_q, display_d, pending_q, pending_d;
  logic                         pending_valid_q, pending_valid_d;
  logic                         enter_show, boundary;
  logic [NUM_DIGITS-1:0]        lz_blank;
  logic [3:0]                   nibble;
  logic [6:0]                   seg;
  logic                         lit;
  logic [6:0]                   out7_d;
  logic                         dp_d;
  logic [NUM_DIGITS-1:0]        en_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    presc_d    = presc_q + 1'b1;
    enter_show = 1'b0;
    unique case (state_q)
      DEAD: begin
        if (presc_q == DeadLast) begin
          state_d    = SHOW;
          presc_d    = '0;
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (presc_q == ShowLast) begin
          presc_d = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          if (DEAD_CYCLES == 0) begin
            enter_show = 1'b1;
          end else begin
            state_d = DEAD;
          end
        end
      end
      default: state_d = DEAD;
    endcase
    boundary = enter_show && (idx_d == '0);
  end

  // Double buffer: display only changes on a frame boundary; Load on the boundary bypasses.
  always_comb begin
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (boundary) begin
      if (Load) begin
        display_d       = Value;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        display_d       = pending_q;
        pending_valid_d = 1'b0;
      end
    end else if (Load) begin
      pending_d       = Value;
      pending_valid_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic lead;
    lz_blank = '0;
    lead     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && display_d[i] == 4'h0) begin
        lz_blank[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign nibble = display_d[idx_d];

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (seg)
  );

  // Outputs are computed from next-state so they change on the same edge as the state.
  always_comb begin
    lit    = (state_d == SHOW) && !BlankMask[idx_d] && !lz_blank[idx_d];
    out7_d = lit ? seg : SEG_OFF;
    dp_d   = lit ? ~DpIn[idx_d] : 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en_d[i] = ~(lit && (idx_d == IW'(i)));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= DEAD;
      idx_q           <= '0;
      presc_q         <= '0;
      display_q       <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      out7            <= SEG_OFF;
      dp_out          <= 1'b1;
      en_out          <= '1;
      FrameTick       <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      presc_q         <= presc_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      out7            <= out7_d;
      dp_out          <= dp_d;
      en_out          <= en_d;
      FrameTick       <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (4 digits, 4-cycle slots, 1 dead cycle).
// Build with LEADING_ZERO_BLANK_EN defined to match an RTL built with that option.
module tb_seven_seg_scanner;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;
  localparam int unsigned D = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;
  logic [3:0]  DpIn = '0;
  logic [3:0]  BlankMask = '0;
  logic [6:0]  out7;
  logic        dp_out;
  logic [3:0]  en_out;
  logic        FrameTick;

  seven_seg_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Value     (Value),
    .Load      (Load),
    .DpIn      (DpIn),
    .BlankMask (BlankMask),
    .out7      (out7),
    .dp_out    (dp_out),
    .en_out    (en_out),
    .FrameTick (FrameTick)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         frame;
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   chk[int];
  int   off = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(int f, logic [3:0] en, logic [6:0] seg, logic dp);
    exp_t e;
    e.frame = f;
    e.en    = en;
    e.seg   = seg;
    e.dp    = dp;
    exp_q.push_back(e);
    chk[f] = 1'b1;
  endfunction

  // Monitor: one expectation per lit slot of each checked frame, plus per-cycle invariants.
  int         frame_cnt = 0;
  bit         prev_lit = 1'b0;
  int         run = 0;
  logic [3:0] cur_en;
  logic [6:0] cur_seg;
  logic       cur_dp;
  exp_t       e;

  always @(negedge Clk) begin
    if (!Reset) begin
      frame_cnt = 0;
      prev_lit  = 1'b0;
      run       = 0;
    end else begin
      if (FrameTick) begin
        if (chk.exists(frame_cnt)) begin
          check("frame drained", 32'(exp_q.size() > 0 && exp_q[0].frame == frame_cnt), 0);
          while (exp_q.size() > 0 && exp_q[0].frame == frame_cnt) void'(exp_q.pop_front());
        end
        frame_cnt++;
      end
      if (en_out == 4'hF) begin
        check("dark seg", out7, 7'h7F);
        check("dark dp", dp_out, 1'b1);
        if (prev_lit) check("slot length", run, R);
        run      = 0;
        prev_lit = 1'b0;
      end else if (!prev_lit) begin
        prev_lit = 1'b1;
        run      = 1;
        cur_en   = en_out;
        cur_seg  = out7;
        cur_dp   = dp_out;
        if (chk.exists(frame_cnt)) begin
          if (exp_q.size() > 0 && exp_q[0].frame == frame_cnt) begin
            e = exp_q.pop_front();
            check("slot en", en_out, e.en);
            check("slot seg", out7, e.seg);
            check("slot dp", dp_out, e.dp);
          end else begin
            check("unexpected lit slot", en_out, 4'hF);
          end
        end
      end else begin
        run++;
        check("slot hold", {en_out, out7, dp_out}, {cur_en, cur_seg, cur_dp});
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge Clk);
      #2;
      off++;
    end
  endtask

  task automatic wait_frame(input int exp_n);
    int n = 0;
    do begin
      @(posedge Clk);
      #2;
      n++;
    end while (!FrameTick && n < 60);
    check("frame period", n, exp_n);
    off = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    Value = v;
    Load  = 1'b1;
    step(1);
    Load  = 1'b0;
    Value = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out7"}, out7, 7'h7F);
    check({tag, " en_out"}, en_out, 4'hF);
    check({tag, " dp_out"}, dp_out, 1'b1);
    check({tag, " FrameTick"}, FrameTick, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clk);
    #2;
    check_reset_outputs("reset");

    // Frame 1 shows the reset display (all zeros).
    push(1, 4'hE, 7'h40, 1'b1);
    push(1, 4'hD, 7'h40, 1'b1);
    push(1, 4'hB, 7'h40, 1'b1);
    push(1, 4'h7, 7'h40, 1'b1);
    Reset = 1'b1;
    wait_frame(1);
    check("first slot en", en_out, 4'hE);
    step(1);
    check("tick width", FrameTick, 1'b0);

    // Mid-frame load appears only from the next frame.
    push(2, 4'hE, 7'h0E, 1'b1);
    push(2, 4'hD, 7'h30, 1'b1);
    push(2, 4'hB, 7'h08, 1'b1);
    push(2, 4'h7, 7'h79, 1'b1);
    step(2);
    do_load(16'h1A3F);
    wait_frame(16);

    // Two loads in one frame: last wins.
    push(3, 4'hE, 7'h24, 1'b1);
    push(3, 4'hD, 7'h24, 1'b1);
    push(3, 4'hB, 7'h24, 1'b1);
    push(3, 4'h7, 7'h24, 1'b1);
    // Frame 4: boundary bypass load, digit 2 blanked, dp on digit 0.
    push(4, 4'hE, 7'h30, 1'b0);
    push(4, 4'hD, 7'h30, 1'b1);
    push(4, 4'h7, 7'h30, 1'b1);
    step(2);
    do_load(16'h1111);
    step(5);
    do_load(16'h2222);
    wait_frame(11);

    step(19);
    Value     = 16'h3333;
    Load      = 1'b1;
    BlankMask = 4'b0100;
    DpIn      = 4'b0001;
    step(1);
    check("boundary tick", FrameTick, 1'b1);
    Load  = 1'b0;
    Value = '0;
    off   = 0;

    push(5, 4'hE, 7'h40, 1'b1);
    push(5, 4'hD, 7'h12, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
    push(5, 4'hB, 7'h40, 1'b1);
    push(5, 4'h7, 7'h40, 1'b1);
`endif
    step(5);
    do_load(16'h0050);
    step(13);
    BlankMask = '0;
    DpIn      = '0;
    wait_frame(1);

    push(6, 4'hE, 7'h40, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
    push(6, 4'hD, 7'h40, 1'b1);
    push(6, 4'hB, 7'h40, 1'b1);
    push(6, 4'h7, 7'h40, 1'b1);
`endif
    step(3);
    do_load(16'h0000);
    wait_frame(16);

    push(7, 4'hE, 7'h79, 1'b1);
    push(7, 4'hD, 7'h24, 1'b1);
    push(7, 4'hB, 7'h19, 1'b1);
    push(7, 4'h7, 7'h00, 1'b1);
    step(3);
    do_load(16'h8421);
    wait_frame(16);

    // Asynchronous reset in the middle of slot 2.
    step(11);
    check("pre-reset en", en_out, 4'hB);
    check("pre-reset seg", out7, 7'h19);
    Reset = 1'b0;
    #1;
    check_reset_outputs("async reset");
    exp_q.delete();
    chk.delete();
    push(1, 4'hE, 7'h40, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
    push(1, 4'hD, 7'h40, 1'b1);
    push(1, 4'hB, 7'h40, 1'b1);
    push(1, 4'h7, 7'h40, 1'b1);
`endif
    step(2);
    Reset = 1'b1;
    wait_frame(1);
    check("restart en", en_out, 4'hE);
    check("restart seg", out7, 7'h40);
    wait_frame(20);
    step(1);
    check("queue empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
